// File: rtl/requant_stage.sv
// Requantizes int32 conv1d accumulators to int8 in 3 cycles; the whole pipe stalls when the output is held.
// Define REQUANT_PER_CHANNEL_EN for per-channel bias/mult/shift tables instead of single registers.
module requant_stage #(
  parameter int MAX_CHANNELS = 128,
  parameter int PIPE_STAGES  = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_acc,
  input  logic [6:0]  in_channel,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  input  logic        cfg_we,
  input  logic [2:0]  cfg_sel,
  input  logic [6:0]  cfg_idx,
  input  logic [31:0] cfg_data
);

  logic [31:0] bias_rd, mult_rd;
  logic [5:0]  shift_rd;
  logic        unused_ok;

`ifdef REQUANT_PER_CHANNEL_EN
  logic [31:0] bias_q  [MAX_CHANNELS];
  logic [31:0] mult_q  [MAX_CHANNELS];
  logic [5:0]  shift_q [MAX_CHANNELS];

  always_ff @(posedge clk) begin
    if (!reset && cfg_we) begin
      case (cfg_sel)
        3'd0: bias_q[cfg_idx]  <= cfg_data;
        3'd1: mult_q[cfg_idx]  <= cfg_data;
        3'd2: shift_q[cfg_idx] <= cfg_data[5:0];
        default: ;
      endcase
    end
  end

  // Combinational read of registered tables: a same-cycle write is seen only by later beats.
  assign bias_rd  = bias_q[in_channel];
  assign mult_rd  = mult_q[in_channel];
  assign shift_rd = shift_q[in_channel];
`else
  logic [31:0] bias_q, mult_q;
  logic [5:0]  shift_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      bias_q  <= 32'd0;
      mult_q  <= 32'h4000_0000;
      shift_q <= 6'd0;
    end else if (cfg_we) begin
      case (cfg_sel)
        3'd0: bias_q  <= cfg_data;
        3'd1: mult_q  <= cfg_data;
        3'd2: shift_q <= cfg_data[5:0];
        default: ;
      endcase
    end
  end

  assign bias_rd  = bias_q;
  assign mult_rd  = mult_q;
  assign shift_rd = shift_q;
`endif

  logic [31:0] offset_q;
  logic [7:0]  act_min_q, act_max_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      offset_q  <= 32'd0;
      act_min_q <= 8'h80;
      act_max_q <= 8'h7F;
    end else if (cfg_we) begin
      case (cfg_sel)
        3'd3: offset_q  <= cfg_data;
        3'd4: act_min_q <= cfg_data[7:0];
        3'd5: act_max_q <= cfg_data[7:0];
        default: ;
      endcase
    end
  end

  logic        s1_vld_q, s2_vld_q, out_vld_q;
  logic [31:0] s1_x_q, s1_mult_q, s2_y_q;
  logic [5:0]  s1_shift_q, s2_rsh_q;
  logic [7:0]  out_data_q;

  // Stage 2: optional left shift, then rounding doubling high multiply.
  logic [4:0]         lsh;
  logic [31:0]        xs, y_d;
  logic signed [63:0] prod, rnd;
  logic [5:0]         rsh_d;

  assign lsh   = s1_shift_q[5] ? 5'd0 : s1_shift_q[4:0];
  assign xs    = s1_x_q << lsh;
  assign prod  = $signed({{32{xs[31]}}, xs}) * $signed({{32{s1_mult_q[31]}}, s1_mult_q});
  assign rnd   = prod + 64'sd1073741824;
  assign y_d   = (xs == 32'h8000_0000 && s1_mult_q == 32'h8000_0000) ? 32'h7FFF_FFFF : rnd[62:31];
  assign rsh_d = s1_shift_q[5] ? (6'd0 - s1_shift_q) : 6'd0;

  // Stage 3: round half away from zero on the magnitude, then offset and clamp.
  logic               neg;
  logic [33:0]        mag, half, q;
  logic signed [34:0] v, sum, amin, amax, clamped;
  logic [7:0]         res_d;

  assign neg  = s2_y_q[31];
  assign mag  = neg ? (34'd0 - {{2{s2_y_q[31]}}, s2_y_q}) : {2'b00, s2_y_q};
  assign half = (s2_rsh_q == 6'd0) ? 34'd0 : (34'd1 << (s2_rsh_q - 6'd1));
  assign q    = (mag + half) >> s2_rsh_q;
  assign v    = neg ? -$signed({1'b0, q}) : $signed({1'b0, q});
  assign sum  = v + $signed({{3{offset_q[31]}}, offset_q});
  assign amin = $signed({{27{act_min_q[7]}}, act_min_q});
  assign amax = $signed({{27{act_max_q[7]}}, act_max_q});

  always_comb begin
    clamped = sum;
    if (clamped < amin) clamped = amin;
    if (clamped > amax) clamped = amax;
    res_d = clamped[7:0];
  end

  assign in_ready = !reset && (!out_vld_q || out_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_vld_q   <= 1'b0;
      s2_vld_q   <= 1'b0;
      out_vld_q  <= 1'b0;
      out_data_q <= 8'h00;
    end else if (in_ready) begin
      s1_vld_q   <= in_valid;
      s1_x_q     <= in_acc + bias_rd;
      s1_mult_q  <= mult_rd;
      s1_shift_q <= shift_rd;
      s2_vld_q   <= s1_vld_q;
      s2_y_q     <= y_d;
      s2_rsh_q   <= rsh_d;
      out_vld_q  <= s2_vld_q;
      if (s2_vld_q) out_data_q <= res_d;
    end
  end

  assign out_valid = out_vld_q;
  assign out_data  = out_data_q;

`ifdef REQUANT_PER_CHANNEL_EN
  assign unused_ok = ^{rnd[63], clamped[34:8], 1'(PIPE_STAGES != 3)};
`else
  assign unused_ok = ^{rnd[63], clamped[34:8], cfg_idx, in_channel,
                       1'(PIPE_STAGES != 3), 1'(MAX_CHANNELS != 128)};
`endif

endmodule

// File: doc/requant_stage.md
REQUANT_STAGE -- requirements
Module: requant_stage

Interface
REQ-001 Parameter MAX_CHANNELS, 128, number of per-channel table entries; channel index width 7 bits.
REQ-002 Parameter PIPE_STAGES, 3, fixed pipeline depth; other values are not supported.
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  accumulator beat present.
REQ-006 in_ready  output  1  stage accepts beat; transfer occurs when in_valid and in_ready are both high.
REQ-007 in_acc  input  32  signed conv1d accumulator.
REQ-008 in_channel  input  7  output channel of the beat.
REQ-009 out_valid  output  1  requantized byte present.
REQ-010 out_ready  input  1  consumer accepts byte.
REQ-011 out_data  output  8  signed int8 result.
REQ-012 cfg_we  input  1  config write strobe.
REQ-013 cfg_sel  input  3  target: 0 bias, 1 multiplier, 2 shift, 3 output_offset, 4 act_min, 5 act_max; 6-7 ignored.
REQ-014 cfg_idx  input  7  channel index for sel 0-2.
REQ-015 cfg_data  input  32  write value; shift uses [5:0] signed; act_min/act_max use [7:0] signed.

Function
REQ-016 Stage 1 SHALL register x = in_acc + bias[ch] with 32-bit wraparound, and SHALL fetch mult[ch] and shift[ch] in the same cycle the beat is accepted.
REQ-017 Stage 2 SHALL left-shift x by max(shift,0) with wraparound, then compute the saturating rounding doubling high multiply (x*mult + 2^30) >>> 31 using a 64-bit product.
REQ-018 Stage 2 SHALL output 0x7FFFFFFF when x and mult are both 0x80000000.
REQ-019 Stage 3 SHALL apply a rounding divide by 2^max(-shift,0), rounding half away from zero.
REQ-020 Stage 3 SHALL add output_offset and clamp the result to [act_min, act_max]; out_data is the low 8 bits.
REQ-021 Latency SHALL be exactly 3 cycles from the accept edge to out_valid when no stall occurs.
REQ-022 in_ready SHALL equal !out_valid || out_ready, and the whole pipeline advances only when in_ready is high.
REQ-023 Throughput SHALL be one beat per cycle with out_ready held high.
REQ-024 While out_valid is high and out_ready is low, out_data SHALL hold stable and no beat is dropped or reordered.
REQ-025 A config write takes effect for beats accepted on later cycles; on a same-cycle write and accept to the same channel, the beat SHALL use the old value.
REQ-026 Beats already in flight SHALL use the table values fetched when they were accepted.
REQ-027 If act_min > act_max, the result SHALL be act_max (the max clamp is applied last).
REQ-028 cfg_sel 6-7 writes SHALL be no-ops.

Reset
REQ-029 While reset is high: all stage valids clear, out_valid = 0, in_ready = 0, and inputs are ignored.
REQ-030 Reset values: out_data 0x00, output_offset 0, act_min -128, act_max 127.
REQ-031 Per-channel tables are not reset.
REQ-032 Reset asserted mid-operation SHALL discard in-flight beats; in_ready is 1 on the first cycle after release.

Configuration
REQ-033 Macro REQUANT_PER_CHANNEL_EN.
- Defined: bias, mult and shift are MAX_CHANNELS-entry tables indexed by in_channel and cfg_idx.
- Undefined: each is a single register; cfg_idx and in_channel are ignored; reset values bias 0, mult 0x40000000, shift 0.

Verification
REQ-034 Config bias 0, mult 0x40000000, shift 0, offset 0; in_acc 100 -> out_data 50, 3 cycles after accept.
REQ-035 Same config; in_acc 3 -> out_data 2 (rounding); in_acc -100 with shift -2 -> out_data -13 (0xF3).
REQ-036 mult 0x80000000, in_acc 0x80000000, bias 0 -> saturate, then clamp -> out_data 127; in_acc 1000 with mult 0x7FFFFFFF and offset -10 -> out_data 127.
REQ-037 Four consecutive beats (acc 2, 4, 6, 8), out_ready low for 5 cycles -> in_ready drops, then outputs 1, 2, 3, 4 in order with no loss.
REQ-038 Channel 5 bias 10 and channel 6 bias -10, in_acc 20 on each -> 15 and 5; on the same-cycle cfg write to channel 5 bias plus accept, the old bias is used.
REQ-039 Reset pulsed while 2 beats are in flight -> out_valid 0 and no stale output after release.
